// File: rtl/bus_matrix_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// Define BUS_MATRIX_ARB_TIMEOUT_EN to build the unacknowledged-cycle watchdog and ABORT state.
module bus_matrix_wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx_o,
  output logic                           s_cyc_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic                           timeout_o
);

  localparam int unsigned MAX_MASTERS = 16;
  localparam int unsigned IDX_W       = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W       = 16;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
    $error("bus_matrix_wb_arbiter: NUM_MASTERS out of range");
  end

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ABORT} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_GRANT} state_t;
`endif

  state_t                 r_state;
  logic [IDX_W-1:0]       r_last_idx;
  logic [IDX_W-1:0]       w_cand;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_vld;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic                   w_own_cyc;

  // Round-robin search starting one past the last owner
  always_comb begin
    w_cand    = '0;
    w_win_idx = '0;
    w_win_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = IDX_W'((32'(r_last_idx) + i) % NUM_MASTERS);
      if (!w_win_vld && m_cyc_i[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  assign w_win_oh  = NUM_MASTERS'(1) << w_win_idx;
  assign w_own_cyc = m_cyc_i[grant_idx_o];

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_to_cnt;
  logic             w_beat_done;
  logic             w_fire;

  assign w_beat_done = s_ack_i | s_err_i;
  assign w_fire      = (r_to_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`else
  logic w_unused;
  assign w_unused  = ^{s_ack_i, s_err_i, CNT_W'(TIMEOUT_CYCLES)};
  assign m_err_o   = '0;
  assign timeout_o = 1'b0;
`endif

  // Arbitration FSM with registered outputs; a release always wins over a timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      grant_o     <= '0;
      grant_idx_o <= '0;
      s_cyc_o     <= 1'b0;
      r_last_idx  <= IDX_W'(NUM_MASTERS - 1);
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
      m_err_o     <= '0;
      timeout_o   <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
      m_err_o   <= '0;
      timeout_o <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_state     <= ST_GRANT;
            grant_o     <= w_win_oh;
            grant_idx_o <= w_win_idx;
            s_cyc_o     <= 1'b1;
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!w_own_cyc) begin
            r_state     <= ST_IDLE;
            grant_o     <= '0;
            grant_idx_o <= '0;
            s_cyc_o     <= 1'b0;
            r_last_idx  <= grant_idx_o;
          end
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
          else if (w_beat_done) begin
            r_to_cnt <= '0;
          end else if (w_fire) begin
            r_state   <= ST_ABORT;
            timeout_o <= 1'b1;
            m_err_o   <= grant_o;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
`endif
        end
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
        ST_ABORT: begin
          r_state     <= ST_IDLE;
          grant_o     <= '0;
          grant_idx_o <= '0;
          s_cyc_o     <= 1'b0;
          r_last_idx  <= grant_idx_o;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_matrix_wb_arbiter.sv
// Scoreboard bench for bus_matrix_wb_arbiter: stimulus pushes per-cycle expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_bus_matrix_wb_arbiter;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] m_cyc_i;
  logic       s_ack_i;
  logic       s_err_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       s_cyc_o;
  logic [3:0] m_err_o;
  logic       timeout_o;

  bus_matrix_wb_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m_cyc_i     (m_cyc_i),
    .s_ack_i     (s_ack_i),
    .s_err_i     (s_err_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .s_cyc_o     (s_cyc_o),
    .m_err_o     (m_err_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    logic [3:0] grant;
    logic [3:0] err;
    logic       to;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cur_tag = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic [3:0] cyc, input logic ack, input logic err, input logic rst,
                      input logic [3:0] eg, input logic [3:0] ee, input logic et);
    exp_t e;
    @(negedge clk_i);
    m_cyc_i = cyc;
    s_ack_i = ack;
    s_err_i = err;
    rst_i   = rst;
    e.grant = eg;
    e.err   = ee;
    e.to    = et;
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic g(input logic [3:0] cyc, input logic [3:0] eg);
    step(cyc, 1'b0, 1'b0, 1'b0, eg, 4'b0000, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [1:0] eidx;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        eidx = idx_of(e.grant);
        checks++;
        if (grant_o !== e.grant || grant_idx_o !== eidx || s_cyc_o !== (|e.grant) ||
            m_err_o !== e.err || timeout_o !== e.to) begin
          errors++;
          $display("FAIL test%0d t=%0t: got grant=%b idx=%0d scyc=%b err=%b to=%b, want grant=%b idx=%0d scyc=%b err=%b to=%b",
                   e.tag, $time, grant_o, grant_idx_o, s_cyc_o, m_err_o, timeout_o,
                   e.grant, eidx, |e.grant, e.err, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    m_cyc_i = 4'b0000;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;

    // Reset state
    cur_tag = 0;
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    g(4'b0000, 4'b0000);

    // Single request from master 1
    cur_tag = 1;
    repeat (5) g(4'b0010, 4'b0010);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);

    // Contention: fresh reset, order 0,1,2,3,0 with one idle cycle between owners
    cur_tag = 2;
    step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'(1 << k);
      repeat (3) g(4'b1111, oh);
      g(~oh, 4'b0000);
    end
    g(4'b1111, 4'b0001);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);

    // Wrap-around after master 3, then a request withdrawn before grant
    cur_tag = 3;
    g(4'b1000, 4'b1000);
    g(4'b1000, 4'b1000);
    g(4'b0000, 4'b0000);
    g(4'b1001, 4'b0001);
    g(4'b1001, 4'b0001);
    g(4'b1000, 4'b0000);
    g(4'b1000, 4'b1000);
    g(4'b0000, 4'b0000);
    g(4'b0001, 4'b0001);
    g(4'b0101, 4'b0001);
    g(4'b0001, 4'b0001);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);

    // Reset while master 2 holds the bus
    cur_tag = 4;
    g(4'b0100, 4'b0100);
    g(4'b0100, 4'b0100);
    step(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step(4'b0101, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    g(4'b0101, 4'b0001);
    g(4'b0101, 4'b0001);
    g(4'b0100, 4'b0000);
    g(4'b0100, 4'b0100);
    g(4'b0000, 4'b0000);

    // Release on the cycle a timeout would fire: no abort
    cur_tag = 5;
    g(4'b0010, 4'b0010);
    repeat (7) g(4'b0010, 4'b0010);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);

    // Master 1 never acknowledged
    cur_tag = 6;
    g(4'b0010, 4'b0010);
    repeat (7) g(4'b0010, 4'b0010);
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
    step(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);
`else
    repeat (6) g(4'b0010, 4'b0010);
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);
`endif

    // Periodic ack/err keeps the watchdog quiet for 50 cycles
    cur_tag = 7;
    g(4'b0010, 4'b0010);
    for (int c = 1; c <= 50; c++) begin
      logic a;
      logic e;
      a = (c % 7 == 0) && (c != 21);
      e = (c == 21);
      step(4'b0010, a, e, 1'b0, 4'b0010, 4'b0000, 1'b0);
    end
    g(4'b0000, 4'b0000);
    g(4'b0000, 4'b0000);

    // Final reset
    cur_tag = 8;
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk_i);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
